// File: rtl/fetch_queue_frontend_if.sv
// Fetch front-end bundle: I-cache request/response, predictor query, redirect and decode-side queue head.
// Latency: none, this file only groups signals.
// Backpressure: fetch_request_ready throttles I-cache requests, fetch_out_ready throttles decode delivery.
interface fetch_queue_frontend_if #(
    parameter int XLEN        = 32,
    parameter int QUEUE_DEPTH = 4
);
    logic                             fetch_request_valid;
    logic                             fetch_request_ready;
    logic [XLEN-1:0]                  fetch_request_address;
    logic                             fetch_response_valid;
    logic [31:0]                      fetch_response_instruction;
    logic [XLEN-1:0]                  predict_program_counter;
    logic                             prediction_taken;
    logic [XLEN-1:0]                  prediction_target;
    logic                             redirect_valid;
    logic [XLEN-1:0]                  redirect_pc;
    logic                             fetch_out_valid;
    logic                             fetch_out_ready;
    logic [XLEN-1:0]                  fetch_out_program_counter;
    logic [31:0]                      fetch_out_instruction;
    logic                             fetch_out_prediction_taken;
    logic [XLEN-1:0]                  fetch_out_prediction_target;
    logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count;

    // Fetch stage side
    modport master (
        output fetch_request_valid, fetch_request_address, predict_program_counter,
               fetch_out_valid, fetch_out_program_counter, fetch_out_instruction,
               fetch_out_prediction_taken, fetch_out_prediction_target, queue_count,
        input  fetch_request_ready, fetch_response_valid, fetch_response_instruction,
               prediction_taken, prediction_target, redirect_valid, redirect_pc, fetch_out_ready
    );

    // Environment side: I-cache, predictor, backend and decode
    modport slave (
        input  fetch_request_valid, fetch_request_address, predict_program_counter,
               fetch_out_valid, fetch_out_program_counter, fetch_out_instruction,
               fetch_out_prediction_taken, fetch_out_prediction_target, queue_count,
        output fetch_request_ready, fetch_response_valid, fetch_response_instruction,
               prediction_taken, prediction_target, redirect_valid, redirect_pc, fetch_out_ready
    );
endinterface

// File: rtl/fetch_queue_frontend.sv
// Decoupled fetch: PC generation, one-outstanding I-cache request, QUEUE_DEPTH-entry instruction queue to decode.
// Latency: response to fetch_out_valid 1 cycle; 0 cycles when FETCH_QUEUE_BYPASS_EN is defined and the queue is empty.
// Backpressure: requests are credit-limited by count+outstanding < QUEUE_DEPTH; a stalled decode fills the queue then halts fetch.
module fetch_queue_frontend #(
    parameter int              XLEN        = 32,
    parameter int              QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fetch_queue_frontend_if.master fq
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    logic [XLEN-1:0] pc_q;
    logic            outstanding_q;
    logic            drop_q;
    logic [XLEN-1:0] pend_pc_q;
    logic            pend_taken_q;
    logic [XLEN-1:0] pend_target_q;

    logic [XLEN-1:0] q_pc     [QUEUE_DEPTH];
    logic [31:0]     q_instr  [QUEUE_DEPTH];
    logic            q_taken  [QUEUE_DEPTH];
    logic [XLEN-1:0] q_target [QUEUE_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic [CW:0]     inflight;
    logic            credit_ok;
    logic            req_vld;
    logic            accept;
    logic            resp_fire;
    logic            resp_keep;
    logic            queue_vld;
    logic            bypass;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] pc_next;

    // Handshake decode: a queue slot is reserved for every request in flight, so a push never meets a full queue
    always_comb begin
        inflight  = {1'b0, count_q} + {{CW{1'b0}}, outstanding_q};
        credit_ok = inflight < (CW+1)'(QUEUE_DEPTH);
        req_vld   = rst_n && !fq.redirect_valid && (!outstanding_q || fq.fetch_response_valid) && credit_ok;
        accept    = req_vld && fq.fetch_request_ready;
        resp_fire = outstanding_q && fq.fetch_response_valid;
        resp_keep = resp_fire && !drop_q && !fq.redirect_valid;
        queue_vld = (count_q != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass    = resp_keep && !queue_vld;
`else
        bypass    = 1'b0;
`endif
        push      = resp_keep && !(bypass && fq.fetch_out_ready);
        pop       = queue_vld && fq.fetch_out_ready && !fq.redirect_valid;
        pc_next   = fq.prediction_taken ? fq.prediction_target : pc_q + XLEN'(4);
    end

    // Outputs: request side follows the PC register, decode side shows the queue head or the bypassed response
    always_comb begin
        fq.fetch_request_valid         = req_vld;
        fq.fetch_request_address       = pc_q;
        fq.predict_program_counter     = pc_q;
        fq.queue_count                 = count_q;
        fq.fetch_out_valid             = queue_vld || bypass;
        fq.fetch_out_program_counter   = q_pc[rd_ptr_q];
        fq.fetch_out_instruction       = q_instr[rd_ptr_q];
        fq.fetch_out_prediction_taken  = q_taken[rd_ptr_q];
        fq.fetch_out_prediction_target = q_target[rd_ptr_q];
        if (bypass) begin
            fq.fetch_out_program_counter   = pend_pc_q;
            fq.fetch_out_instruction       = fq.fetch_response_instruction;
            fq.fetch_out_prediction_taken  = pend_taken_q;
            fq.fetch_out_prediction_target = pend_target_q;
        end
    end

    // PC, outstanding-request and drop tracking; a redirect overrides any accept or response that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            pend_pc_q     <= '0;
            pend_taken_q  <= 1'b0;
            pend_target_q <= '0;
        end else if (fq.redirect_valid) begin
            pc_q <= {fq.redirect_pc[XLEN-1:2], 2'b00};
            if (outstanding_q) begin
                if (fq.fetch_response_valid) begin
                    outstanding_q <= 1'b0;
                    drop_q        <= 1'b0;
                end else begin
                    drop_q <= 1'b1;
                end
            end
        end else if (accept) begin
            pc_q          <= pc_next;
            outstanding_q <= 1'b1;
            drop_q        <= 1'b0;
            pend_pc_q     <= pc_q;
            pend_taken_q  <= fq.prediction_taken;
            pend_target_q <= fq.prediction_target;
        end else if (resp_fire) begin
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (fq.redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // Queue storage write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc[i]     <= '0;
                q_instr[i]  <= '0;
                q_taken[i]  <= 1'b0;
                q_target[i] <= '0;
            end
        end else if (push) begin
            q_pc[wr_ptr_q]     <= pend_pc_q;
            q_instr[wr_ptr_q]  <= fq.fetch_response_instruction;
            q_taken[wr_ptr_q]  <= pend_taken_q;
            q_target[wr_ptr_q] <= pend_target_q;
        end
    end
endmodule

// File: tb/tb_fetch_queue_frontend.sv
// Directed bench: I-cache and predictor models drive the front-end, a monitor checks delivered entries from a queue.
// Latency: cache answers lat cycles after an accepted request.
// Backpressure: decode ready and cache ready are driven per phase by the stimulus.
module tb_fetch_queue_frontend;
    localparam int XLEN = 32;
    localparam int QD   = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_frontend_if #(.XLEN(XLEN), .QUEUE_DEPTH(QD)) ifc ();

    fetch_queue_frontend #(.XLEN(XLEN), .QUEUE_DEPTH(QD), .RESET_PC(32'h100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fq    (ifc)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    // Predictor model: taken only at one chosen PC
    logic        pred_en = 1'b0;
    logic [31:0] pred_at = '0;
    logic [31:0] pred_tgt = '0;
    assign ifc.prediction_taken  = pred_en && (ifc.predict_program_counter == pred_at);
    assign ifc.prediction_target = ifc.prediction_taken ? pred_tgt : 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        exp_t e;
        e.pc     = pc;
        e.instr  = instr_of(pc);
        e.taken  = taken;
        e.target = tgt;
        exp_q.push_back(e);
    endtask

    // I-cache model: one request at a time, answers lat cycles after acceptance
    int          lat = 1;
    int          cd = 0;
    logic [31:0] acc_addr = '0;
    initial begin
        ifc.fetch_response_valid       = 1'b0;
        ifc.fetch_response_instruction = '0;
        forever begin
            @(negedge clk);
            ifc.fetch_response_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    ifc.fetch_response_valid       = 1'b1;
                    ifc.fetch_response_instruction = instr_of(acc_addr);
                end
            end
            #1;
            if (rst_n && ifc.fetch_request_valid && ifc.fetch_request_ready) begin
                acc_addr = ifc.fetch_request_address;
                cd       = lat;
            end
        end
    end

    // Monitor: every head consumed by decode is compared against the next expected entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && ifc.fetch_out_valid && ifc.fetch_out_ready && !ifc.redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got pc %h, none expected", ifc.fetch_out_program_counter);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", ifc.fetch_out_program_counter, e.pc);
                    chk("out_instr", ifc.fetch_out_instruction, e.instr);
                    chk("out_taken", 32'(ifc.fetch_out_prediction_taken), 32'(e.taken));
                    chk("out_target", ifc.fetch_out_prediction_target, e.target);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic drain(input string name);
        repeat (5) @(negedge clk);
        #2;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        ifc.fetch_request_ready = 1'b0;
        ifc.fetch_out_ready     = 1'b0;
        ifc.redirect_valid      = 1'b0;
        ifc.redirect_pc         = '0;

        // Reset state
        #12;
        chk("rst_req_valid", 32'(ifc.fetch_request_valid), 0);
        chk("rst_req_addr", ifc.fetch_request_address, 32'h100);
        chk("rst_pred_pc", ifc.predict_program_counter, 32'h100);
        chk("rst_out_valid", 32'(ifc.fetch_out_valid), 0);
        chk("rst_count", 32'(ifc.queue_count), 0);
        chk("rst_out_pc", ifc.fetch_out_program_counter, 0);
        chk("rst_out_instr", ifc.fetch_out_instruction, 0);

        // Sequential stream 0x100, 0x104, 0x108 with decode ready
        exp_push(32'h100, 1'b0, 32'h0);
        exp_push(32'h104, 1'b0, 32'h0);
        exp_push(32'h108, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ifc.fetch_request_ready = 1'b1;
        ifc.fetch_out_ready     = 1'b1;
        #2;
        chk("t1_req_valid", 32'(ifc.fetch_request_valid), 1);
        chk("t1_req_addr", ifc.fetch_request_address, 32'h100);
        @(negedge clk);
        #2;
        chk("t1_resp_cycle_out_valid", 32'(ifc.fetch_out_valid), 32'(BYP));
        chk("t1_resp_cycle_count", 32'(ifc.queue_count), 0);
        @(negedge clk);
        #2;
        chk("t1_next_cycle_out_valid", 32'(ifc.fetch_out_valid), 1);
        chk("t1_next_cycle_count", 32'(ifc.queue_count), BYP ? 0 : 1);
        @(negedge clk);
        ifc.fetch_request_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t1_count_le1", 32'(ifc.queue_count <= 1), 1);
            @(negedge clk);
        end
        drain("t1_drained");

        // Decode stalled: queue fills to 4, fetch halts at 0x10C+16
        exp_push(32'h10C, 1'b0, 32'h0);
        exp_push(32'h110, 1'b0, 32'h0);
        exp_push(32'h114, 1'b0, 32'h0);
        exp_push(32'h118, 1'b0, 32'h0);
        @(negedge clk);
        ifc.fetch_out_ready     = 1'b0;
        ifc.fetch_request_ready = 1'b1;
        repeat (7) @(negedge clk);
        #2;
        chk("t2_count_full", 32'(ifc.queue_count), 4);
        chk("t2_req_stalled", 32'(ifc.fetch_request_valid), 0);
        chk("t2_pc_held", ifc.fetch_request_address, 32'h11C);
        @(negedge clk);
        ifc.fetch_out_ready     = 1'b1;
        ifc.fetch_request_ready = 1'b0;
        #2;
        chk("t2_release_req_valid", 32'(ifc.fetch_request_valid), 0);
        @(negedge clk);
        #2;
        chk("t2_resume_req_valid", 32'(ifc.fetch_request_valid), 1);
        drain("t2_drained");

        // Idle redirect to 0x107 (low bits cleared), then predicted-taken branch at 0x108 -> 0x200
        exp_push(32'h104, 1'b0, 32'h0);
        exp_push(32'h108, 1'b1, 32'h200);
        exp_push(32'h200, 1'b0, 32'h0);
        @(negedge clk);
        ifc.redirect_valid      = 1'b1;
        ifc.redirect_pc         = 32'h107;
        ifc.fetch_request_ready = 1'b1;
        pred_en  = 1'b1;
        pred_at  = 32'h108;
        pred_tgt = 32'h200;
        #2;
        chk("t3_redirect_no_req", 32'(ifc.fetch_request_valid), 0);
        @(negedge clk);
        ifc.redirect_valid = 1'b0;
        #2;
        chk("t3_addr_104", ifc.fetch_request_address, 32'h104);
        @(negedge clk);
        #2;
        chk("t3_addr_108", ifc.fetch_request_address, 32'h108);
        @(negedge clk);
        #2;
        chk("t3_addr_200", ifc.fetch_request_address, 32'h200);
        @(negedge clk);
        ifc.fetch_request_ready = 1'b0;
        pred_en = 1'b0;
        drain("t3_drained");

        // Redirect to 0x400 while 0x204 is outstanding; its response 3 cycles later is dropped
        exp_push(32'h400, 1'b0, 32'h0);
        @(negedge clk);
        lat = 3;
        ifc.fetch_request_ready = 1'b1;
        #2;
        chk("t4_addr_204", ifc.fetch_request_address, 32'h204);
        @(negedge clk);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h400;
        #2;
        chk("t4_redirect_no_req", 32'(ifc.fetch_request_valid), 0);
        @(negedge clk);
        ifc.redirect_valid = 1'b0;
        lat = 1;
        #2;
        chk("t4_waiting_no_req", 32'(ifc.fetch_request_valid), 0);
        chk("t4_count_zero", 32'(ifc.queue_count), 0);
        @(negedge clk);
        #2;
        chk("t4_req_after_drop", 32'(ifc.fetch_request_valid), 1);
        chk("t4_addr_400", ifc.fetch_request_address, 32'h400);
        @(negedge clk);
        ifc.fetch_request_ready = 1'b0;
        drain("t4_drained");

        // Redirect coincident with a response and a would-be pop: nothing delivered, count 0
        exp_push(32'h500, 1'b0, 32'h0);
        @(negedge clk);
        ifc.fetch_out_ready     = 1'b0;
        ifc.fetch_request_ready = 1'b1;
        #2;
        chk("t5_addr_404", ifc.fetch_request_address, 32'h404);
        @(negedge clk);
        @(negedge clk);
        ifc.redirect_valid  = 1'b1;
        ifc.redirect_pc     = 32'h500;
        ifc.fetch_out_ready = 1'b1;
        #2;
        chk("t5_pre_count", 32'(ifc.queue_count), 1);
        chk("t5_resp_present", 32'(ifc.fetch_response_valid), 1);
        chk("t5_redirect_no_req", 32'(ifc.fetch_request_valid), 0);
        @(negedge clk);
        ifc.redirect_valid = 1'b0;
        #2;
        chk("t5_count_flushed", 32'(ifc.queue_count), 0);
        chk("t5_out_valid", 32'(ifc.fetch_out_valid), 0);
        chk("t5_req_valid", 32'(ifc.fetch_request_valid), 1);
        chk("t5_addr_500", ifc.fetch_request_address, 32'h500);
        @(negedge clk);
        ifc.fetch_request_ready = 1'b0;
        drain("t5_drained");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
